// File: rtl/ma4_track.sv
// Running-best score tracker for the banded Smith-Waterman max-reduction tree.
// Tracks the best wavefront max, its PE and wavefront index, and hands the result off on valid/ready.
module ma4_track #(
  parameter int H_W   = 7,
  parameter int P_W   = 2,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [P_W-1:0]   ma_p,
  input  logic [H_W-1:0]   ma_out,
  input  logic             in_last,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [H_W-1:0]   best_score,
  output logic [P_W-1:0]   best_pe,
  output logic [CYC_W-1:0] best_cyc,
  output logic [CYC_W-1:0] best_ref
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CYC_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CYC_W-1:0] cnt;

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // reset clears every output register, so the result is never X after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      best_score <= '0;
      best_pe    <= '0;
      best_cyc   <= '0;
      best_ref   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= '0;
            best_score <= '0;
            best_pe    <= '0;
            best_cyc   <= '0;
            best_ref   <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            // Strict compare: ties keep the earlier wavefront, matching the tree's tie rule.
            if (ma_out > best_score) begin
              best_score <= ma_out;
              best_pe    <= ma_p;
              best_cyc   <= cnt;
              best_ref   <= cnt - CYC_W'(ma_p);
            end
            if (cnt != CNT_MAX) cnt <= cnt + CYC_W'(1);
            if (in_last) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma4_track.sv
// Randomized self-checking bench for ma4_track: an 8-bit and a 4-bit counter build share
// the same stimulus and are both checked every cycle against an argmax-style reference model.
module tb_ma4_track;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] ma_p = '0;
  logic [6:0] ma_out = '0;

  logic       busy8, ov8, busy4, ov4;
  logic [6:0] score8, score4;
  logic [1:0] pe8, pe4;
  logic [7:0] cyc8, ref8;
  logic [3:0] cyc4, ref4;

  ma4_track #(.H_W(7), .P_W(2), .CYC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .ma_p(ma_p),
    .ma_out(ma_out), .in_last(in_last), .busy(busy8), .out_valid(ov8),
    .out_ready(out_ready), .best_score(score8), .best_pe(pe8), .best_cyc(cyc8),
    .best_ref(ref8)
  );

  ma4_track #(.H_W(7), .P_W(2), .CYC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .ma_p(ma_p),
    .ma_out(ma_out), .in_last(in_last), .busy(busy4), .out_valid(ov4),
    .out_ready(out_ready), .best_score(score4), .best_pe(pe4), .best_cyc(cyc4),
    .best_ref(ref4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=run 2=done; best tracked by beat ordinal.
  int m_phase = 0, m_cnt = 0, m_score = 0, m_idx = 0, m_pe = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_score = 0; m_idx = 0; m_pe = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_cnt = 0; m_score = 0; m_idx = 0; m_pe = 0;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        if (int'(ma_out) > m_score) begin
          m_score = int'(ma_out); m_idx = m_cnt; m_pe = int'(ma_p);
        end
        m_cnt++;
        if (in_last) m_phase = 2;
      end
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  function automatic int exp_cyc(input int w);
    int mx = (1 << w) - 1;
    return (m_idx > mx) ? mx : m_idx;
  endfunction

  function automatic int exp_ref(input int w);
    return (exp_cyc(w) - m_pe) & ((1 << w) - 1);
  endfunction

  initial forever begin
    @(negedge clk);
    check("busy8", int'(busy8), int'(m_phase != 0));
    check("valid8", int'(ov8), int'(m_phase == 2));
    check("score8", int'(score8), m_score);
    check("pe8", int'(pe8), m_pe);
    check("cyc8", int'(cyc8), exp_cyc(8));
    check("ref8", int'(ref8), exp_ref(8));
    check("busy4", int'(busy4), int'(m_phase != 0));
    check("valid4", int'(ov4), int'(m_phase == 2));
    check("score4", int'(score4), m_score);
    check("pe4", int'(pe4), m_pe);
    check("cyc4", int'(cyc4), exp_cyc(4));
    check("ref4", int'(ref4), exp_ref(4));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input int s, input int p, input bit l);
    ma_out = 7'(s); ma_p = 2'(p); in_valid = 1'b1; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !ov8; i++) tick();
    check("valid_timeout", int'(ov8), 1);
  endtask

  task automatic handshake(input int delay);
    repeat (delay) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", int'(ov8), 0);
  endtask

  // Literal expectations pin both the DUT and the model.
  task automatic lit(input string tag, input int s, input int p, input int c8, input int r8,
                     input int c4, input int r4);
    check({tag, "_score"}, int'(score8), s);
    check({tag, "_pe"}, int'(pe8), p);
    check({tag, "_cyc8"}, int'(cyc8), c8);
    check({tag, "_ref8"}, int'(ref8), r8);
    check({tag, "_cyc4"}, int'(cyc4), c4);
    check({tag, "_ref4"}, int'(ref4), r4);
    check({tag, "_mscore"}, m_score, s);
    check({tag, "_mref8"}, exp_ref(8), r8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", int'(busy8), 0);
    check("rst_valid", int'(ov8), 0);
    check("rst_score", int'(score8), 0);
    check("rst_ref", int'(ref8), 0);
    rst_n = 1'b1;
    tick();

    // Basic max; an in_valid pulse in IDLE must be ignored.
    beat(50, 1, 1'b0);
    do_start();
    beat(5, 1, 0); beat(12, 3, 0); beat(9, 0, 0); beat(12, 2, 0); beat(3, 1, 1);
    check("basic_valid_latency", int'(ov8), 1);
    lit("basic", 12, 3, 1, 254, 1, 14);
    handshake(0);

    // Tie keeps the first entry.
    do_start();
    beat(7, 2, 0); beat(7, 0, 1);
    wait_valid();
    lit("tie", 7, 2, 0, 254, 0, 14);
    handshake(1);

    // Gaps, start ignored in RUN and DONE, backpressure, immediate restart.
    do_start();
    beat(0, 0, 0); tick();
    do_start();
    beat(100, 1, 0); tick(); tick();
    beat(127, 3, 1);
    wait_valid();
    do_start();
    beat(20, 0, 0);
    lit("gap", 127, 3, 2, 255, 2, 15);
    handshake(5);
    do_start();
    check("restart_busy", int'(busy8), 1);
    beat(0, 0, 1);
    wait_valid();
    lit("zero", 0, 0, 0, 0, 0, 0);
    handshake(0);

    // Saturation of the 4-bit counter build.
    do_start();
    for (int i = 0; i < 18; i++) beat(int'($urandom_range(0, 50)), int'($urandom_range(0, 3)), 0);
    beat(100, 1, 0);
    lit("sat18", 100, 1, 18, 17, 15, 14);
    beat(120, 2, 1);
    wait_valid();
    lit("sat19", 120, 2, 19, 17, 15, 13);
    handshake(2);

    // Asynchronous reset mid-RUN.
    do_start();
    beat(20, 1, 0); beat(30, 2, 0); beat(10, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy8), 0);
    check("arst_score", int'(score8), 0);
    check("arst_pe", int'(pe8), 0);
    check("arst_cyc", int'(cyc8), 0);
    check("arst_ref", int'(ref8), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    beat(40, 3, 0); beat(40, 1, 0); beat(60, 0, 1);
    wait_valid();
    lit("post_rst", 60, 0, 2, 2, 2, 2);
    handshake(0);

    // Randomized alignments with gaps, junk in IDLE, ties and early out_ready.
    for (int a = 0; a < 30; a++) begin
      int len = int'($urandom_range(1, 25));
      bit narrow = ($urandom_range(0, 1) == 1);
      bit early = ($urandom_range(0, 3) == 0);
      repeat (int'($urandom_range(0, 2))) begin
        in_valid = ($urandom_range(0, 1) == 1);
        ma_out = 7'($urandom_range(0, 127));
        tick();
        in_valid = 1'b0;
      end
      do_start();
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          start = ($urandom_range(0, 1) == 1);
          tick();
          start = 1'b0;
        end
        if (b == len - 1 && early) out_ready = 1'b1;
        beat(narrow ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 127)),
             int'($urandom_range(0, 3)), b == len - 1);
      end
      if (early) begin
        tick();
        out_ready = 1'b0;
        check("early_accept", int'(ov8), 0);
      end else begin
        wait_valid();
        handshake(int'($urandom_range(0, 4)));
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ma4_track.md
# ma4_track

Sequential score tracker that sits downstream of the 4-PE max-reduction tree in the banded Smith-Waterman array. Each valid beat carries one wavefront's maximum H score and the index (0-3) of the PE that produced it. The block keeps the running best score over one alignment, together with the wavefront count and PE index where it occurred. At the end of the alignment it presents the result on a valid/ready handshake to the host/traceback side.

## Interface
Parameters:
- H_W, 7, width of H scores
- P_W, 2, width of PE index (4 PEs)
- CYC_W, 8, width of wavefront counter and reference-index output

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a new alignment (accepted only in IDLE)
- in_valid  input  1  ma_p/ma_out/in_last valid this cycle
- ma_p  input  P_W  PE index of this wavefront's max
- ma_out  input  H_W  wavefront max H score (unsigned)
- in_last  input  1  this beat is the final wavefront (qualified by in_valid)
- busy  output  1  high in RUN and DONE
- out_valid  output  1  result valid (DONE state)
- out_ready  input  1  consumer accepts result
- best_score  output  H_W  best H seen
- best_pe  output  P_W  PE index of best
- best_cyc  output  CYC_W  wavefront number (0-based) of best
- best_ref  output  CYC_W  reference index = best_cyc - best_pe, modulo 2^CYC_W

## Operation
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- Reset state: IDLE.
- Reset values: busy=0, out_valid=0, best_score=0, best_pe=0, best_cyc=0, best_ref=0. Internal wavefront counter = 0.
- IDLE:
  - start=1 clears best_* and the counter to 0, then moves to RUN.
  - in_valid is ignored in IDLE.
- RUN, on each in_valid beat:
  - If ma_out > best_score (strict), load best_score=ma_out, best_pe=ma_p, best_cyc=counter, best_ref=counter-ma_p.
  - Ties keep the earlier entry, which matches the tree's lower-index-on-tie rule.
  - Counter then increments, saturating at 2^CYC_W-1; no wrap.
  - A beat with in_valid=1 and in_last=1 is evaluated first, then the FSM moves to DONE.
- RUN without in_valid: hold everything.
- start is ignored in RUN and DONE.
- DONE:
  - out_valid=1 and best_* are held stable.
  - When out_valid and out_ready are both high, the FSM returns to IDLE.
  - best_* keep their values in IDLE until the next start.
- All-zero alignment: best_score=0, best_pe=0, best_cyc=0, best_ref=0. A zero input never beats the initial 0.
- best_ref arithmetic: CYC_W-bit unsigned subtraction. Underflow wraps, e.g. counter 0, pe 2 gives 2^CYC_W-2. The consumer discards such out-of-band values.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Update latency: best_* reflect a beat one cycle after that beat is sampled.
- out_valid rises in the cycle after the in_last beat is sampled. best_* already include the last beat in that cycle.
- Handshake:
  - Completes on the edge where out_valid=1 and out_ready=1.
  - out_valid is low the next cycle.
  - out_ready held high before DONE causes acceptance on the first DONE cycle.
- Back-to-back alignments: start is only honored in IDLE. The earliest new start is sampled in the cycle after the handshake completes.
- Reset asserted mid-RUN or mid-DONE: all outputs and the counter go to reset values immediately. Any partial alignment is lost.

## Test plan
- Basic max: start; beats (score, pe) = (5,1), (12,3), (9,0), (12,2), last on (3,1).
  - Expect out_valid one cycle after the last beat.
  - Expect best_score=12, best_pe=3, best_cyc=1, best_ref=254 (CYC_W=8).
- Tie and strictness: beats (7,2), (7,0) with last.
  - Expect best_pe=2, best_cyc=0. The tie keeps the first entry.
- Gaps and ignored inputs:
  - in_valid pulses in IDLE are ignored.
  - start pulses in RUN and DONE are ignored.
  - Idle cycles between beats do not advance the counter.
  - Beats (0,0), gap, (100,1), gap, (127,3) with last: best_cyc=2, best_ref=255, best_score=127.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and best_* stay stable.
  - Raising out_ready gives one handshake, then IDLE; a start the next cycle is accepted.
- Saturation: CYC_W=4 build, 20 beats with max score on beat 18.
  - best_cyc=15 (saturated). A later strictly larger score still updates with best_cyc=15.
- Reset mid-operation: assert rst_n=0 asynchronously during RUN after 3 beats.
  - All outputs are 0 immediately and the FSM is in IDLE.
  - A new alignment afterwards produces correct results.
